if_fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline register. It owns the PC and masters a

---
 rtl/cpu_pkg.sv | 13 +
 rtl/if_skid_buf.sv | 55 +++++
 rtl/if_fetch_stage.sv | 157 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage state type.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [31:0] PC_ADDR_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} parking buffer used when ID stalls on a completed fetch.
module if_skid_buf
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  drain,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] instr_in,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instr
);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;

  // Emptying (drain or clear) wins over a same-cycle load.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear || drain) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= DATA_WIDTH'(NOP_INSTR);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, masters a Wishbone-classic imem port, feeds IF/ID.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(PC_ADDR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  use_branch,
  input  logic [ADDR_WIDTH-1:0] branch_out,
  output logic                  imem_cyc_o,
  output logic                  imem_stb_o,
  output logic [ADDR_WIDTH-1:0] imem_adr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_dat_i,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  if_valid
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  if_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  kill_q, kill_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  cyc_q, cyc_d;
  logic                  if_valid_q, if_valid_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;

  logic                  buf_load, buf_drain, buf_clear;
  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_pc;
  logic [DATA_WIDTH-1:0] buf_instr;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  // Redirect targets are always word aligned.
  assign redirect_pc = branch_out & ALIGN_MASK;

  if_skid_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (buf_load),
    .drain    (buf_drain),
    .clear    (buf_clear),
    .pc_in    (pc_q),
    .instr_in (imem_dat_i),
    .valid    (buf_valid),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  // Next-state, PC sequencing and IF/ID load decisions.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    pend_pc_d  = pend_pc_q;
    if_valid_d = stall ? if_valid_q : 1'b0;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    buf_load   = 1'b0;
    buf_drain  = 1'b0;
    buf_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (use_branch) pc_d = redirect_pc;
      end
      FETCH: begin
        if (imem_ack_i) begin
          if (kill_q || use_branch) begin
            // Word belongs to the wrong path; newest redirect target wins.
            pc_d   = use_branch ? redirect_pc : pend_pc_q;
            kill_d = 1'b0;
          end else if (flush) begin
            pc_d = pc_q + PC_STEP;
          end else if (!stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_dat_i;
            pc_d       = pc_q + PC_STEP;
          end else begin
            buf_load = 1'b1;
            pc_d     = pc_q + PC_STEP;
            state_d  = HOLD;
          end
        end else if (use_branch) begin
          // Address must stay stable until ack; remember the redirect instead.
          kill_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end
      HOLD: begin
        if (use_branch) begin
          buf_clear = 1'b1;
          pc_d      = redirect_pc;
          state_d   = FETCH;
        end else if (flush) begin
          buf_clear = 1'b1;
          state_d   = FETCH;
        end else if (!stall) begin
          buf_drain  = 1'b1;
          if_valid_d = buf_valid;
          if_pc_d    = buf_pc;
          if_instr_d = buf_instr;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) if_valid_d = 1'b0;
    cyc_d = (state_d == FETCH);
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= PC_ADDR;
      kill_q     <= 1'b0;
      pend_pc_q  <= PC_ADDR;
      cyc_q      <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= PC_ADDR;
      if_instr_q <= DATA_WIDTH'(NOP_INSTR);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      pend_pc_q  <= pend_pc_d;
      cyc_q      <= cyc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_cyc_o = cyc_q;
  assign imem_stb_o = cyc_q;
  assign imem_adr_o = pc_q;
  assign if_valid   = if_valid_q;
  assign if_pc      = if_pc_q;
  assign if_instr   = if_instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a stream-level reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] PC0 = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        use_branch;
  logic [31:0] branch_out;
  logic        imem_cyc_o;
  logic        imem_stb_o;
  logic [31:0] imem_adr_o;
  logic        imem_ack_i;
  logic [31:0] imem_dat_i;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int          n_pass;
  int          n_total;
  bit          ack_en;

  // Model state
  logic [31:0] exp_pc;
  bit          prev_hold;
  logic [31:0] prev_adr;

  if_fetch_stage #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .PC_ADDR    (PC0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .flush      (flush),
    .use_branch (use_branch),
    .branch_out (branch_out),
    .imem_cyc_o (imem_cyc_o),
    .imem_stb_o (imem_stb_o),
    .imem_adr_o (imem_adr_o),
    .imem_ack_i (imem_ack_i),
    .imem_dat_i (imem_dat_i),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_valid   (if_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Advance one clock; slave answers every presented cycle while ack_en is set.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_ack_i = imem_cyc_o && ack_en;
    imem_dat_i = mem_word(imem_adr_o);
  endtask

  // Stream model: every instruction ID accepts must be the next PC of the program order,
  // carry the memory word at that PC, and the bus address must hold until ack.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_pc    = PC0;
      prev_hold = 1'b0;
      check("rst_cyc", 32'(imem_cyc_o), 32'd0);
      check("rst_valid", 32'(if_valid), 32'd0);
    end else begin
      check("stb_eq_cyc", 32'(imem_stb_o), 32'(imem_cyc_o));
      if (prev_hold) begin
        check("cyc_held", 32'(imem_cyc_o), 32'd1);
        check("adr_stable", imem_adr_o, prev_adr);
      end
      prev_hold = imem_cyc_o && !imem_ack_i;
      prev_adr  = imem_adr_o;
      if (if_valid && !stall && !flush) begin
        check("stream_pc", if_pc, exp_pc);
        check("stream_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (use_branch) exp_pc = branch_out & ~32'd3;
    end
  end

  initial begin
    n_pass     = 0;
    n_total    = 0;
    reset_n    = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    use_branch = 1'b0;
    branch_out = '0;
    imem_ack_i = 1'b0;
    imem_dat_i = '0;
    ack_en     = 1'b1;

    // Reset values
    repeat (3) tick();
    check("reset_cyc", 32'(imem_cyc_o), 32'd0);
    check("reset_adr", imem_adr_o, PC0);
    check("reset_if_valid", 32'(if_valid), 32'd0);
    check("reset_if_pc", if_pc, PC0);
    check("reset_if_instr", if_instr, NOP);

    // 1: release, zero-wait ack every cycle
    reset_n = 1'b1;
    tick();                                   // R1: first fetch presented
    check("t1_cyc", 32'(imem_cyc_o), 32'd1);
    check("t1_adr0", imem_adr_o, 32'h8000_0000);
    check("t1_valid0", 32'(if_valid), 32'd0);
    tick();                                   // R2
    check("t1_instr_lit", if_instr, 32'h25A5_5A5A);
    for (int k = 2; k <= 6; k++) begin
      if (k > 2) tick();
      check("t1_valid", 32'(if_valid), 32'd1);
      check("t1_if_pc", if_pc, PC0 + 32'(4 * (k - 2)));
      check("t1_adr", imem_adr_o, PC0 + 32'(4 * (k - 1)));
    end

    // 2: stall for 3 cycles while fetch of _0014 is acked
    stall = 1'b1;                             // R6
    for (int k = 0; k < 3; k++) begin
      tick();                                 // R7..R9
      check("t2_frozen_pc", if_pc, 32'h8000_0010);
      check("t2_bus_idle", 32'(imem_cyc_o), 32'd0);
    end
    stall = 1'b0;                             // R9
    tick();                                   // R10
    check("t2_drain_pc", if_pc, 32'h8000_0014);
    check("t2_drain_valid", 32'(if_valid), 32'd1);
    check("t2_resume_adr", imem_adr_o, 32'h8000_0018);
    tick();                                   // R11
    check("t2_next_pc", if_pc, 32'h8000_0018);

    // 3: redirect while ack is withheld for 4 cycles
    ack_en = 1'b0;
    tick();                                   // R12
    check("t3_adr_start", imem_adr_o, 32'h8000_0020);
    use_branch = 1'b1;
    branch_out = 32'h8000_0101;
    for (int k = 0; k < 3; k++) begin
      tick();                                 // R13..R15
      use_branch = 1'b0;
      branch_out = '0;
      check("t3_adr_hold", imem_adr_o, 32'h8000_0020);
    end
    ack_en = 1'b1;
    tick();                                   // R16: ack on stale word
    check("t3_adr_ack", imem_adr_o, 32'h8000_0020);
    tick();                                   // R17
    check("t3_new_adr", imem_adr_o, 32'h8000_0100);
    check("t3_discarded", 32'(if_valid), 32'd0);
    tick();                                   // R18
    check("t3_target_pc", if_pc, 32'h8000_0100);
    check("t3_target_valid", 32'(if_valid), 32'd1);

    // 4: flush + redirect under stall with ack
    tick();                                   // R19
    stall      = 1'b1;
    flush      = 1'b1;
    use_branch = 1'b1;
    branch_out = 32'h8000_0200;
    tick();                                   // R20
    check("t4_killed", 32'(if_valid), 32'd0);
    check("t4_adr", imem_adr_o, 32'h8000_0200);
    stall      = 1'b0;
    flush      = 1'b0;
    use_branch = 1'b0;
    branch_out = '0;
    tick();                                   // R21
    check("t4_pc", if_pc, 32'h8000_0200);
    check("t4_valid", 32'(if_valid), 32'd1);

    // 5: park a word, then flush + redirect to the top of the address space
    stall = 1'b1;
    tick();                                   // R22: HOLD
    check("t5_hold_idle", 32'(imem_cyc_o), 32'd0);
    flush      = 1'b1;
    use_branch = 1'b1;
    branch_out = 32'hFFFF_FFFC;
    tick();                                   // R23
    check("t5_adr_top", imem_adr_o, 32'hFFFF_FFFC);
    check("t5_killed", 32'(if_valid), 32'd0);
    stall      = 1'b0;
    flush      = 1'b0;
    use_branch = 1'b0;
    branch_out = '0;
    tick();                                   // R24
    check("t5_wrap_adr", imem_adr_o, 32'h0000_0000);
    check("t5_top_pc", if_pc, 32'hFFFF_FFFC);
    tick();                                   // R25
    check("t5_wrap_pc", if_pc, 32'h0000_0000);

    // 6: reset in the middle of an unacknowledged transaction
    ack_en = 1'b0;
    tick();                                   // R26
    check("t6_pre_cyc", 32'(imem_cyc_o), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_cyc_drop", 32'(imem_cyc_o), 32'd0);
    check("t6_stb_drop", 32'(imem_stb_o), 32'd0);
    check("t6_adr_reset", imem_adr_o, PC0);
    ack_en = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_restart_adr", imem_adr_o, PC0);
    check("t6_restart_cyc", 32'(imem_cyc_o), 32'd1);
    tick();
    check("t6_restart_pc", if_pc, PC0);
    check("t6_restart_valid", 32'(if_valid), 32'd1);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
